// File: rtl/ram_param.sv
// ram_param: single-port synchronous RAM with a hardware clear sweep after reset or on clr.
// Read latency is 1 cycle: dataOut/dataValid update on the edge that samples rd. Writes land on the sampling edge.
// busy is high during a sweep, and we/rd are dropped while it is high. Build option RAM_PARAM_BYPASS_EN makes a same-edge we&rd write-first.
module ram_param #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic [ADDR_WIDTH-1:0] address,
  input  logic [DATA_WIDTH-1:0] dataIn,
  input  logic                  we,
  input  logic                  rd,
  input  logic                  clr,
  output logic [DATA_WIDTH-1:0] dataOut,
  output logic                  dataValid,
  output logic                  busy
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] LAST_PTR = ADDR_WIDTH'(DEPTH - 1);

  typedef enum logic {
    CLEAR = 1'b0,
    READY = 1'b1
  } state_t;

  state_t                  state;
  state_t                  state_nxt;
  logic [ADDR_WIDTH-1:0]   clr_ptr;
  logic [ADDR_WIDTH-1:0]   clr_ptr_nxt;

  logic                    mem_we;
  logic [ADDR_WIDTH-1:0]   mem_addr;
  logic [DATA_WIDTH-1:0]   mem_wdata;
  logic                    rd_en;
  logic [DATA_WIDTH-1:0]   rd_data;

  logic [DATA_WIDTH-1:0]   mem [DEPTH];

  // State and sweep pointer register; reset always starts a fresh sweep from address 0.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state   <= CLEAR;
      clr_ptr <= '0;
    end else begin
      state   <= state_nxt;
      clr_ptr <= clr_ptr_nxt;
    end
  end

  // Next state and memory port steering: the sweep owns the port in CLEAR, user accesses own it in READY.
  always_comb begin
    state_nxt   = state;
    clr_ptr_nxt = clr_ptr;
    mem_we      = 1'b0;
    mem_addr    = address;
    mem_wdata   = dataIn;
    rd_en       = 1'b0;
    case (state)
      CLEAR: begin
        mem_we    = 1'b1;
        mem_addr  = clr_ptr;
        mem_wdata = '0;
        if (clr) begin
          clr_ptr_nxt = '0;
        end else begin
          clr_ptr_nxt = clr_ptr + ADDR_WIDTH'(1);
          if (clr_ptr == LAST_PTR) begin
            state_nxt = READY;
          end
        end
      end
      READY: begin
        if (clr) begin
          // A clear request wins over any access on the same edge.
          state_nxt   = CLEAR;
          clr_ptr_nxt = '0;
        end else begin
          mem_we = we;
          rd_en  = rd;
        end
      end
      default: begin
        state_nxt   = CLEAR;
        clr_ptr_nxt = '0;
      end
    endcase
  end

  // Read data source for a same-edge write to the addressed word.
`ifdef RAM_PARAM_BYPASS_EN
  assign rd_data = we ? dataIn : mem[address];
`else
  assign rd_data = mem[address];
`endif

  // Storage array, deliberately without reset; the clear sweep zeroes it instead.
  always_ff @(posedge clock) begin
    if (mem_we) begin
      mem[mem_addr] <= mem_wdata;
    end
  end

  // Registered read port; dataOut holds between accepted reads, and dataValid pulses once per read.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      dataOut   <= '0;
      dataValid <= 1'b0;
    end else begin
      dataValid <= rd_en;
      if (rd_en) begin
        dataOut <= rd_data;
      end
    end
  end

  assign busy = (state == CLEAR);

endmodule

// File: tb/tb_ram_param.sv
// Bench for ram_param: default 8x16 instance checked every cycle against a word-level model, plus a 16x64 instance.
// Model view: a sweep is a countdown of DEPTH edges that leaves memory all-zero, and accesses are dropped while it runs.
// Directed literal checks pin the model at the interesting points.
module tb_ram_param;

`ifdef RAM_PARAM_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic       clock = 1'b0;
  logic       reset_n;
  logic [3:0] address;
  logic [7:0] dataIn;
  logic       we, rd, clr;
  logic [7:0] dataOut;
  logic       dataValid, busy;

  logic        w_rst;
  logic [5:0]  w_addr;
  logic [15:0] w_din;
  logic        w_we, w_rd, w_clr;
  logic [15:0] w_dout;
  logic        w_vld, w_busy;

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;

  always #5 clock = ~clock;

  ram_param dut (
    .clock(clock), .reset_n(reset_n), .address(address), .dataIn(dataIn),
    .we(we), .rd(rd), .clr(clr), .dataOut(dataOut), .dataValid(dataValid), .busy(busy)
  );

  ram_param #(.DATA_WIDTH(16), .ADDR_WIDTH(6)) dut_w (
    .clock(clock), .reset_n(w_rst), .address(w_addr), .dataIn(w_din),
    .we(w_we), .rd(w_rd), .clr(w_clr), .dataOut(w_dout), .dataValid(w_vld), .busy(w_busy)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model
  logic [7:0] m_mem [16];
  int         m_left;
  logic [7:0] m_out;
  logic       m_vld;

  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      m_left = 16;
      m_out  = 8'h00;
      m_vld  = 1'b0;
      for (int k = 0; k < 16; k++) m_mem[k] = 8'h00;
    end else if (m_left > 0) begin
      m_vld  = 1'b0;
      m_left = clr ? 16 : m_left - 1;
    end else if (clr) begin
      m_vld  = 1'b0;
      m_left = 16;
      for (int k = 0; k < 16; k++) m_mem[k] = 8'h00;
    end else begin
      m_vld = rd;
      if (rd) m_out = (we && BYP) ? dataIn : m_mem[address];
      if (we) m_mem[address] = dataIn;
    end
  end

  always @(negedge clock) begin
    if (chk_en && reset_n) begin
      chk("cyc_busy", {31'd0, busy}, {31'd0, m_left > 0});
      chk("cyc_vld", {31'd0, dataValid}, {31'd0, m_vld});
      chk("cyc_dout", {24'd0, dataOut}, {24'd0, m_out});
    end
  end

  task automatic step(input logic w, input logic r, input logic c,
                      input logic [3:0] a, input logic [7:0] d);
    we = w; rd = r; clr = c; address = a; dataIn = d;
    @(negedge clock);
  endtask

  task automatic count_busy(input int exp, input string name);
    int n;
    n = 0;
    while (busy && n < 200) begin
      @(posedge clock); #1; n++;
    end
    chk(name, n, exp);
    @(negedge clock);
  endtask

  initial begin
    int n;
    reset_n = 1'b1; w_rst = 1'b1;
    we = 0; rd = 0; clr = 0; address = 0; dataIn = 0;
    w_we = 0; w_rd = 0; w_clr = 0; w_addr = 0; w_din = 0;
    #1 reset_n = 1'b0; w_rst = 1'b0;
    repeat (3) @(negedge clock);
    chk("rst_dout", {24'd0, dataOut}, 32'h0);
    chk("rst_vld", {31'd0, dataValid}, 32'h0);
    chk("rst_busy", {31'd0, busy}, 32'h1);

    reset_n = 1'b1;
    chk_en  = 1'b1;
    count_busy(16, "busy_len_por");

    for (int i = 0; i < 16; i++) begin
      step(0, 1, 0, 4'(i), 8'h00);
      chk("init_vld", {31'd0, dataValid}, 32'h1);
      chk("init_dat", {24'd0, dataOut}, 32'h0);
    end
    step(0, 0, 0, 4'd0, 8'h00);
    chk("idle_vld", {31'd0, dataValid}, 32'h0);

    step(1, 0, 0, 4'd3, 8'hA5);
    chk("wr_novld", {31'd0, dataValid}, 32'h0);
    step(0, 1, 0, 4'd3, 8'h00);
    chk("rd3_dat", {24'd0, dataOut}, 32'hA5);
    chk("rd3_vld", {31'd0, dataValid}, 32'h1);
    step(0, 1, 0, 4'd4, 8'h00);
    chk("rd4_dat", {24'd0, dataOut}, 32'h00);
    chk("rd4_vld", {31'd0, dataValid}, 32'h1);
    step(0, 0, 0, 4'd0, 8'h00);
    chk("b2b_end", {31'd0, dataValid}, 32'h0);

    step(1, 0, 0, 4'd5, 8'h11);
    step(1, 1, 0, 4'd5, 8'h22);
    chk("rw_same", {24'd0, dataOut}, BYP ? 32'h22 : 32'h11);
    step(0, 1, 0, 4'd5, 8'h00);
    chk("rw_after", {24'd0, dataOut}, 32'h22);

    for (int i = 0; i < 16; i++) step(1, 0, 0, 4'(i), 8'hFF);
    step(0, 1, 0, 4'd7, 8'h00);
    chk("fill_rd", {24'd0, dataOut}, 32'hFF);
    step(1, 1, 1, 4'd2, 8'h3C);
    chk("clr_novld", {31'd0, dataValid}, 32'h0);
    chk("clr_busy", {31'd0, busy}, 32'h1);
    chk("clr_hold", {24'd0, dataOut}, 32'hFF);
    for (int i = 0; i < 16; i++) begin
      step(0, 1, 0, 4'(i), 8'h00);
      chk("swp_novld", {31'd0, dataValid}, 32'h0);
      chk("swp_busy", {31'd0, busy}, (i < 15) ? 32'h1 : 32'h0);
    end
    for (int i = 0; i < 16; i++) begin
      step(0, 1, 0, 4'(i), 8'h00);
      chk("clr_zero", {24'd0, dataOut}, 32'h0);
    end

    step(1, 0, 0, 4'd9, 8'h5A);
    step(0, 1, 0, 4'd9, 8'h00);
    chk("pre_rst", {24'd0, dataOut}, 32'h5A);
    step(0, 0, 1, 4'd0, 8'h00);
    repeat (7) step(0, 0, 0, 4'd0, 8'h00);
    #3 reset_n = 1'b0;
    #1;
    chk("mid_rst_dout", {24'd0, dataOut}, 32'h0);
    chk("mid_rst_vld", {31'd0, dataValid}, 32'h0);
    chk("mid_rst_busy", {31'd0, busy}, 32'h1);
    @(negedge clock);
    reset_n = 1'b1;
    count_busy(16, "busy_len_rst");
    step(0, 1, 0, 4'd9, 8'h00);
    chk("rst_cleared", {24'd0, dataOut}, 32'h0);
    chk("rst_rd_vld", {31'd0, dataValid}, 32'h1);
    step(0, 0, 0, 4'd0, 8'h00);

    w_rst = 1'b1;
    n = 0;
    while (w_busy && n < 300) begin
      @(posedge clock); #1; n++;
    end
    chk("w_busy_len", n, 64);
    @(negedge clock);
    w_we = 1; w_addr = 6'd63; w_din = 16'hBEEF;
    @(negedge clock);
    w_addr = 6'd0; w_din = 16'h1234;
    @(negedge clock);
    w_we = 0; w_rd = 1; w_addr = 6'd63;
    @(negedge clock);
    chk("w_rd63", {16'd0, w_dout}, 32'hBEEF);
    chk("w_vld63", {31'd0, w_vld}, 32'h1);
    w_addr = 6'd0;
    @(negedge clock);
    chk("w_rd0", {16'd0, w_dout}, 32'h1234);
    w_rd = 0;
    @(negedge clock);
    chk("w_vld_end", {31'd0, w_vld}, 32'h0);

    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
